// File: rtl/cmpe200_pkg.sv
// cmpe200_pkg: branch opcodes, REGIMM sub-codes and resolver FSM states
package cmpe200_pkg;
   localparam logic [5:0] OPC_BEQ    = 6'b000100;
   localparam logic [5:0] OPC_BNE    = 6'b000101;
   localparam logic [5:0] OPC_BLEZ   = 6'b000110;
   localparam logic [5:0] OPC_BGTZ   = 6'b000111;
   localparam logic [5:0] OPC_REGIMM = 6'b000001;
   localparam logic [4:0] RT_BLTZ    = 5'b00000;
   localparam logic [4:0] RT_BGEZ    = 5'b00001;
   typedef enum logic [2:0] {IDLE, RD_RS, RD_RT, EVAL, DONE} state_t;
   function automatic logic is_two_op(input logic [5:0] opc);
      return opc == OPC_BEQ || opc == OPC_BNE;
   endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: branch condition and legality from opcode, REGIMM sub-code and operands
module branch_cond_eval
   import cmpe200_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int DATA_W = 32
) (
   input  logic [5:0]        opcode,
   input  logic [REG_AW-1:0] rt,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              taken,
   output logic              illegal
);
   logic neg, zero;
   always_comb begin
      neg = a[DATA_W-1];
      zero = ~|a;
      taken = opcode == OPC_BEQ  ? a == b :
              opcode == OPC_BNE  ? a != b :
              opcode == OPC_BLEZ ? neg | zero :
              opcode == OPC_BGTZ ? ~neg & ~zero :
              opcode == OPC_REGIMM && rt == RT_BLTZ ? neg :
              opcode == OPC_REGIMM && rt == RT_BGEZ ? ~neg : 1'b0;
      illegal = !(is_two_op(opcode) || opcode == OPC_BLEZ || opcode == OPC_BGTZ ||
                  (opcode == OPC_REGIMM && (rt == RT_BLTZ || rt == RT_BGEZ)));
   end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: multi-cycle branch resolver owning the shared RF read port while busy
module branch_resolve_ctrl
   import cmpe200_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [5:0]        br_opcode,
   input  logic [REG_AW-1:0] br_rs,
   input  logic [REG_AW-1:0] br_rt,
   input  logic [IMM_W-1:0]  br_imm,
   input  logic [DATA_W-1:0] br_pc,
   output logic              rf_rd_en,
   output logic [REG_AW-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              res_valid,
   output logic              res_taken,
   output logic [DATA_W-1:0] res_target,
   output logic              flush,
   output logic              illegal
);
   state_t state, next;
   logic [5:0] opc;
   logic [REG_AW-1:0] rs, rt, last_addr, c_rt;
   logic [IMM_W-1:0] imm;
   logic [DATA_W-1:0] pc, op_a, rd_val, c_a, pc_src, pc4, tgt;
   logic [5:0] c_opc;
   logic two, accept, c_taken, c_illegal, taken_q, illegal_q;
   logic [DATA_W-1:0] target_q;
   branch_cond_eval #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_eval (
      .opcode(c_opc), .rt(c_rt), .a(c_a), .b(rd_val), .taken(c_taken), .illegal(c_illegal)
   );
   // In IDLE the evaluator decodes the incoming instruction so legality is known at accept
   always_comb begin
      accept = br_valid & br_ready;
      two = is_two_op(opc);
      c_opc = state == IDLE ? br_opcode : opc;
      c_rt = state == IDLE ? br_rt : rt;
      last_addr = (state == EVAL && two) ? rt : rs;
      rd_val = last_addr == '0 ? '0 : rf_rdata;
      c_a = (state == EVAL && !two) ? rd_val : op_a;
      pc_src = state == IDLE ? br_pc : pc;
      pc4 = pc_src + DATA_W'(4);
      tgt = c_taken ? pc4 + {{(DATA_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00} : pc4;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= next;
   end
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = accept ? (c_illegal ? DONE : RD_RS) : IDLE;
         RD_RS:   next = two ? RD_RT : EVAL;
         RD_RT:   next = EVAL;
         EVAL:    next = DONE;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         opc <= '0;
         rs <= '0;
         rt <= '0;
         imm <= '0;
         pc <= '0;
         op_a <= '0;
         taken_q <= 1'b0;
         illegal_q <= 1'b0;
         target_q <= '0;
      end else begin
         if (accept) begin
            opc <= br_opcode;
            rs <= br_rs;
            rt <= br_rt;
            imm <= br_imm;
            pc <= br_pc;
            if (c_illegal) begin
               illegal_q <= 1'b1;
               taken_q <= 1'b0;
               target_q <= pc4;
            end
         end
         if (state == RD_RT) op_a <= rd_val;
         if (state == EVAL) begin
            if (!two) op_a <= rd_val;
            taken_q <= c_taken;
            illegal_q <= 1'b0;
            target_q <= tgt;
         end
      end
   end
   always_comb begin
      br_ready = state == IDLE;
      rf_rd_en = state == RD_RS || state == RD_RT;
      rf_raddr = state == RD_RS ? rs : state == RD_RT ? rt : '0;
      res_valid = state == DONE;
      res_taken = taken_q;
      res_target = target_q;
      flush = res_valid & taken_q;
      illegal = illegal_q;
   end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed branches checked by a result scoreboard
module tb_branch_resolve_ctrl;
   typedef struct {
      logic        taken;
      logic [31:0] target;
      logic        ill;
      int          lat;
      int          nrd;
      logic [4:0]  a0;
      logic [4:0]  a1;
   } exp_t;
   logic clk = 0, rst_n = 0, br_valid = 0;
   logic [5:0] br_opcode = 0;
   logic [4:0] br_rs = 0, br_rt = 0;
   logic [15:0] br_imm = 0;
   logic [31:0] br_pc = 0, rf_rdata = 0;
   logic br_ready, rf_rd_en, res_valid, res_taken, flush, illegal;
   logic [4:0] rf_raddr;
   logic [31:0] res_target;
   logic [31:0] rf [32];
   exp_t exp_q[$];
   int acc_q[$];
   logic [4:0] rd_log[$];
   int cyc = 0, n_cmp = 0, n_bad = 0;
   branch_resolve_ctrl dut (
      .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
      .br_opcode(br_opcode), .br_rs(br_rs), .br_rt(br_rt), .br_imm(br_imm), .br_pc(br_pc),
      .rf_rd_en(rf_rd_en), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .flush(flush), .illegal(illegal)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rf_rdata <= rf[rf_raddr];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // Monitor: logs accepts and RF reads, compares every result strobe against the queue head
   always @(negedge clk) begin
      if (!rst_n) begin
         acc_q.delete();
         rd_log.delete();
      end else begin
         if (br_valid && br_ready) acc_q.push_back(cyc);
         if (rf_rd_en) rd_log.push_back(rf_raddr);
         if (res_valid) begin
            if (exp_q.size() == 0) chk("unexpected_res_valid", 1, 0);
            else begin
               exp_t e;
               int a;
               e = exp_q.pop_front();
               a = acc_q.size() > 0 ? acc_q.pop_front() : -100;
               chk("taken", res_taken, e.taken);
               chk("target", res_target, e.target);
               chk("flush", flush, e.taken);
               chk("illegal", illegal, e.ill);
               chk("latency", cyc - a, e.lat);
               chk("n_reads", rd_log.size(), e.nrd);
               if (rd_log.size() > 0 && e.nrd > 0) chk("raddr0", rd_log[0], e.a0);
               if (rd_log.size() > 1 && e.nrd > 1) chk("raddr1", rd_log[1], e.a1);
               rd_log.delete();
            end
         end
      end
   end
   task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [15:0] imm, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic il, input int lat, input int nrd,
                        input logic [4:0] a0, input logic [4:0] a1);
      exp_t e;
      int w;
      e.taken = tk; e.target = tgt; e.ill = il; e.lat = lat; e.nrd = nrd; e.a0 = a0; e.a1 = a1;
      exp_q.push_back(e);
      for (w = 0; w < 20 && !br_ready; w++) begin
         @(posedge clk);
         #1;
      end
      br_valid = 1; br_opcode = op; br_rs = rs; br_rt = rt; br_imm = imm; br_pc = pc;
      @(posedge clk);
      #1 br_valid = 0;
      for (w = 0; w < 40 && exp_q.size() > 0; w++) @(posedge clk);
      #1 chk("drain", exp_q.size(), 0);
   endtask
   initial begin
      int n;
      int t[2];
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rf[0] = 32'hDEADBEEF;
      rf[10] = 10; rf[4] = 10; rf[5] = 32'hFFFFFFF6; rf[1] = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_br_ready", br_ready, 1);
      chk("rst_rf_rd_en", rf_rd_en, 0);
      chk("rst_rf_raddr", rf_raddr, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_taken", res_taken, 0);
      chk("rst_res_target", res_target, 0);
      chk("rst_flush", flush, 0);
      chk("rst_illegal", illegal, 0);
      rst_n = 1;
      @(posedge clk);
      #1;
      issue(6'b000100, 10, 4, 16'h0003, 32'h100, 1, 32'h110, 0, 4, 2, 10, 4);
      rf[4] = 4;
      issue(6'b000101, 10, 4, 16'hFFFF, 32'h200, 1, 32'h200, 0, 4, 2, 10, 4);
      rf[4] = 10;
      issue(6'b000101, 10, 4, 16'hFFFF, 32'h200, 0, 32'h204, 0, 4, 2, 10, 4);
      issue(6'b000001, 5, 0, 16'h0002, 32'h300, 1, 32'h30C, 0, 3, 1, 5, 0);
      issue(6'b000001, 5, 1, 16'h0002, 32'h300, 0, 32'h304, 0, 3, 1, 5, 0);
      issue(6'b000110, 0, 0, 16'h0010, 32'h400, 1, 32'h444, 0, 3, 1, 0, 0);
      issue(6'b000110, 1, 0, 16'h0010, 32'h400, 0, 32'h404, 0, 3, 1, 1, 0);
      issue(6'b000010, 3, 3, 16'h0010, 32'h500, 0, 32'h504, 1, 1, 0, 0, 0);
      issue(6'b000001, 5, 2, 16'h0010, 32'h500, 0, 32'h504, 1, 1, 0, 0, 0);
      issue(6'b000111, 1, 0, 16'h0001, 32'hFFFFFFF8, 1, 32'h0, 0, 3, 1, 1, 0);
      // Abort a BEQ in RD_RT; no result may follow
      br_valid = 1; br_opcode = 6'b000100; br_rs = 10; br_rt = 4; br_imm = 0; br_pc = 32'h700;
      @(posedge clk);
      #1 br_valid = 0;
      @(posedge clk);
      #1 chk("in_rd_rt_raddr", rf_raddr, 4);
      rst_n = 0;
      @(posedge clk);
      #1 rst_n = 1;
      chk("abort_br_ready", br_ready, 1);
      chk("abort_res_valid", res_valid, 0);
      chk("abort_flush", flush, 0);
      chk("abort_target", res_target, 0);
      repeat (6) @(posedge clk);
      #1;
      // Held br_valid: two back-to-back BEQs
      for (int k = 0; k < 2; k++) issue_exp_only(k);
      n = 0;
      br_valid = 1; br_opcode = 6'b000100; br_rs = 10; br_rt = 4; br_imm = 0; br_pc = 32'h600;
      for (int i = 0; i < 20 && n < 2; i++) begin
         @(negedge clk);
         if (br_ready) begin
            t[n] = cyc;
            n++;
         end
      end
      @(posedge clk);
      #1 br_valid = 0;
      chk("held_accepts", n, 2);
      chk("reaccept_gap", t[1] - t[0], 5);
      for (int w = 0; w < 40 && exp_q.size() > 0; w++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1 chk("final_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   task automatic issue_exp_only(input int k);
      exp_t e;
      e.taken = 1; e.target = 32'h604; e.ill = 0; e.lat = 4; e.nrd = 2; e.a0 = 10; e.a1 = 4;
      if (k >= 0) exp_q.push_back(e);
   endtask
endmodule
